hist_fifo_ctrl: RTL

First-word-fall-through FIFO controller that sequences one `dp_ram` instance, write on port a and read on port b with a 1-cycle registered read. It buffers cell-histogram words between the histogram stage and the block-normalisation stage, with valid/ready handshakes on both sides. It hides RAM read latency so the consumer sees one word per cycle at full throughput.

---
 rtl/hog_pkg.sv | 6 +
 rtl/hist_fifo_ctrl_if.sv | 15 +
 rtl/hist_fifo_ctrl_dp_ram.sv | 19 +
 rtl/hist_fifo_ctrl.sv | 66 ++++++
 4 files changed

// File: rtl/hog_pkg.sv
// hog_pkg: shared widths and word type for the HOG histogram pipeline
package hog_pkg;
  localparam int CELL_HIST_W = 180;
  localparam int HIST_BUF_AW = 6;
  typedef logic [CELL_HIST_W-1:0] hist_word_t;
endpackage

// File: rtl/hist_fifo_ctrl_if.sv
// hist_fifo_ctrl_if: producer and consumer valid/ready handshakes of the histogram FIFO
interface hist_fifo_ctrl_if
  import hog_pkg::*;
#(
  parameter int DATA_W = CELL_HIST_W
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/hist_fifo_ctrl_dp_ram.sv
// dp_ram: simple dual-port RAM, write on port a, registered read on port b
module dp_ram #(
  parameter int DATA_W = 180,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (write_en) mem[addr_a] <= data_a;
    if (read_en) data_b <= mem[addr_b];
  end
endmodule

// File: rtl/hist_fifo_ctrl.sv
// hist_fifo_ctrl: first-word-fall-through FIFO around dp_ram with a skid register hiding read latency
module hist_fifo_ctrl
  import hog_pkg::*;
#(
  parameter int DATA_W = CELL_HIST_W,
  parameter int ADDR_W = HIST_BUF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  hist_fifo_ctrl_if.slave   bus,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty
);
  localparam logic [ADDR_W:0] MEM_S = (ADDR_W+1)'(2**ADDR_W);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt, cnt_nxt;
  logic              rov, skv, ready, held, push, pop, rd_en;
  logic [DATA_W-1:0] skid, ram_o;
  assign held = rov | skv;
  assign push = bus.s_valid && ready;
  assign pop = held && bus.m_ready;
  // Refill only when the head slot will be free at the next edge
  assign rd_en = (ram_cnt != '0) && (held == pop);
  assign cnt_nxt = ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd_en);
  assign bus.s_ready = ready;
  assign bus.m_valid = held;
  assign bus.m_data = rov ? ram_o : skid;
  assign o_count = ram_cnt + (ADDR_W+1)'(held);
  assign o_empty = o_count == '0;
  dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .write_en (push && !flush),
    .addr_a   (wr_ptr),
    .data_a   (bus.s_data),
    .read_en  (rd_en && !flush),
    .addr_b   (rd_ptr),
    .data_b   (ram_o)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rov     <= 1'b0;
      skv     <= 1'b0;
      ready   <= 1'b1;
      skid    <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rov     <= 1'b0;
      skv     <= 1'b0;
      ready   <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_W'(push);
      rd_ptr  <= rd_ptr + ADDR_W'(rd_en);
      ram_cnt <= cnt_nxt;
      ready   <= cnt_nxt != MEM_S;
      rov     <= rd_en;
      skv     <= held && !pop;
      if (rov && !pop) skid <= ram_o;
    end
  end
endmodule
